// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one registered ALU between two requesters, round-robin arbitration
// Define ALU_ARB_FIXED_PRI_EN to replace round-robin with fixed priority (req0 > req1).
module alu_arbiter #(
  parameter int W       = 16,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           rsp0_valid,
  output logic [W-1:0]   rsp0_result,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp1_valid,
  output logic [W-1:0]   rsp1_result,
  output logic [OPW-1:0] alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_result,
  output logic           busy,
  output logic           grant_id
);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_e;

  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic           grant_id_q, grant_id_d;
  logic           rsp0_valid_q, rsp0_valid_d;
  logic           rsp1_valid_q, rsp1_valid_d;
  logic [W-1:0]   rsp0_result_q, rsp0_result_d;
  logic [W-1:0]   rsp1_result_q, rsp1_result_d;
  logic           grant0, grant1, accept;

`ifdef ALU_ARB_FIXED_PRI_EN
  assign grant0 = req0_valid;
  assign grant1 = req1_valid & ~req0_valid;
`else
  logic last_grant_q;

  // On a tie the requester that did not win last time goes next.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_grant_q <= 1'b1;
    else if (accept) last_grant_q <= grant1;
  end
`endif

  assign req0_ready = (state_q == IDLE) & grant0 & ~reset;
  assign req1_ready = (state_q == IDLE) & grant1 & ~reset;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    grant_id_d    = grant_id_q;
    rsp0_valid_d  = 1'b0;
    rsp1_valid_d  = 1'b0;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = WAIT;
          cnt_d      = LAT_INIT;
          grant_id_d = grant1;
          alu_op_d   = grant1 ? req1_op : req0_op;
          alu_a_d    = grant1 ? req1_a  : req0_a;
          alu_b_d    = grant1 ? req1_b  : req0_b;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = IDLE;
        if (grant_id_q) begin
          rsp1_valid_d  = 1'b1;
          rsp1_result_d = alu_result;
        end else begin
          rsp0_valid_d  = 1'b1;
          rsp0_result_d = alu_result;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      grant_id_q    <= 1'b0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      grant_id_q    <= grant_id_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
    end
  end

  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign grant_id    = grant_id_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized bench for alu_arbiter against a transaction-level model
// A second instance with ALU_LAT=3 covers the longer-latency timing.
module tb_alu_arbiter;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_v, r1_v, rdy0, rdy1, rv0, rv1, busy, gid;
  logic [2:0]  r0_op, r1_op, alu_op;
  logic [15:0] r0_a, r0_b, r1_a, r1_b, res0, res1, alu_a, alu_b, alu_res;

  logic        t3_v, t3_rdy0, t3_rdy1, t3_rv0, t3_rv1, t3_busy, t3_gid;
  logic [2:0]  t3_op, t3_alu_op;
  logic [15:0] t3_a, t3_b, t3_res0, t3_res1, t3_alu_a, t3_alu_b, t3_alu_res;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(16), .OPW(3), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(r0_v), .req0_ready(rdy0), .req0_op(r0_op), .req0_a(r0_a), .req0_b(r0_b),
    .rsp0_valid(rv0), .rsp0_result(res0),
    .req1_valid(r1_v), .req1_ready(rdy1), .req1_op(r1_op), .req1_a(r1_a), .req1_b(r1_b),
    .rsp1_valid(rv1), .rsp1_result(res1),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_res),
    .busy(busy), .grant_id(gid)
  );

  alu_arbiter #(.W(16), .OPW(3), .ALU_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(t3_v), .req0_ready(t3_rdy0), .req0_op(t3_op), .req0_a(t3_a), .req0_b(t3_b),
    .rsp0_valid(t3_rv0), .rsp0_result(t3_res0),
    .req1_valid(1'b0), .req1_ready(t3_rdy1), .req1_op(3'd0), .req1_a(16'd0), .req1_b(16'd0),
    .rsp1_valid(t3_rv1), .rsp1_result(t3_res1),
    .alu_op(t3_alu_op), .alu_a(t3_alu_a), .alu_b(t3_alu_b), .alu_result(t3_alu_res),
    .busy(t3_busy), .grant_id(t3_gid)
  );

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // Registered one-cycle ALUs attached to each arbiter.
  always @(posedge clk) alu_res    <= alu_f(alu_op, alu_a, alu_b);
  always @(posedge clk) t3_alu_res <= alu_f(t3_alu_op, t3_alu_a, t3_alu_b);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: one op in flight, free again LAT+2 cycles after acceptance.
  int          cyc = 0;
  int          busy_end = -1;
  int          due = -1;
  logic        pend = 1'b0;
  logic        cur_id = 1'b0;
  logic        m_last = 1'b1;
  logic [2:0]  cur_op = 3'd0;
  logic [15:0] cur_a = 16'd0, cur_b = 16'd0, cur_val = 16'd0;
  logic [15:0] m_res0 = 16'd0, m_res1 = 16'd0;

  always @(negedge clk) begin
    logic idle, e0, e1, w0, w1;
    cyc++;
    if (reset) begin
      check_eq("rst_ready0", rdy0, 0);
      check_eq("rst_ready1", rdy1, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rsp_valid", {rv0, rv1}, 0);
      check_eq("rst_results", {res0, res1}, 0);
      check_eq("rst_alu", {alu_op, alu_a, alu_b}, 0);
      check_eq("rst_grant_id", gid, 0);
      pend = 1'b0; busy_end = cyc; m_last = 1'b1; cur_id = 1'b0;
      cur_op = 3'd0; cur_a = 16'd0; cur_b = 16'd0; m_res0 = 16'd0; m_res1 = 16'd0;
    end else begin
      idle = (cyc > busy_end);
      check_eq("busy", busy, !idle);
      check_eq("alu_inputs", {alu_op, alu_a, alu_b}, {cur_op, cur_a, cur_b});
      check_eq("grant_id", gid, cur_id);
      e0 = 1'b0; e1 = 1'b0;
      if (pend && cyc == due) begin
        if (cur_id) begin e1 = 1'b1; m_res1 = cur_val; end
        else        begin e0 = 1'b1; m_res0 = cur_val; end
        pend = 1'b0;
      end
      check_eq("rsp0_valid", rv0, e0);
      check_eq("rsp1_valid", rv1, e1);
      check_eq("rsp0_result", res0, m_res0);
      check_eq("rsp1_result", res1, m_res1);
      w0 = r0_v; w1 = r1_v;
      if (r0_v && r1_v) begin
`ifdef ALU_ARB_FIXED_PRI_EN
        w1 = 1'b0;
`else
        w1 = (m_last == 1'b0);
`endif
        w0 = !w1;
      end
      check_eq("req0_ready", rdy0, idle && w0);
      check_eq("req1_ready", rdy1, idle && w1);
      if (idle && (w0 || w1)) begin
        cur_id   = w1;
        m_last   = w1;
        cur_op   = w1 ? r1_op : r0_op;
        cur_a    = w1 ? r1_a  : r0_a;
        cur_b    = w1 ? r1_b  : r0_b;
        cur_val  = alu_f(cur_op, cur_a, cur_b);
        busy_end = cyc + LAT + 1;
        due      = cyc + LAT + 2;
        pend     = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    r0_v = v; r0_op = op; r0_a = a; r0_b = b;
  endtask

  task automatic set1(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    r1_v = v; r1_op = op; r1_a = a; r1_b = b;
  endtask

  initial begin
    reset = 1'b1;
    t3_v = 1'b0; t3_op = 3'd0; t3_a = 16'd0; t3_b = 16'd0;
    // Both requesters valid continuously from reset release: grants alternate 0,1,0,1.
    set0(1'b1, 3'd0, 16'd1, 16'd1);
    set1(1'b1, 3'd0, 16'd1, 16'd1);
    step(2);
    reset = 1'b0;
    step(12);

    // Single requester 0.
    reset = 1'b1;
    set0(1'b0, 3'd0, 16'd0, 16'd0);
    set1(1'b0, 3'd0, 16'd0, 16'd0);
    step(1);
    reset = 1'b0;
    set0(1'b1, 3'd0, 16'd5, 16'd7);
    step(1);
    set0(1'b0, 3'd0, 16'd0, 16'd0);
    step(4);

    // Requester 1 alone, then both: requester 0 must win the tie.
    set1(1'b1, 3'd0, 16'd100, 16'hFFFF);
    step(1);
    set1(1'b0, 3'd0, 16'd0, 16'd0);
    step(2);
    set0(1'b1, 3'd1, 16'd50, 16'd8);
    set1(1'b1, 3'd0, 16'd9, 16'd9);
    step(3);
    set0(1'b0, 3'd0, 16'd0, 16'd0);
    step(3);
    set1(1'b0, 3'd0, 16'd0, 16'd0);
    step(3);

    // Reset while the op waits on the ALU: no response, then a clean op.
    set0(1'b1, 3'd0, 16'd20, 16'd22);
    step(1);
    set0(1'b0, 3'd0, 16'd0, 16'd0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    set0(1'b1, 3'd0, 16'd3, 16'd4);
    step(1);
    set0(1'b0, 3'd0, 16'd0, 16'd0);
    step(4);

    // Three-cycle ALU latency on the second instance.
    t3_v = 1'b1; t3_op = 3'd0; t3_a = 16'hFFF8; t3_b = 16'd3;
    @(negedge clk);
    check_eq("lat3_ready", t3_rdy0, 1);
    step(1);
    t3_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("lat3_busy", t3_busy, 1);
      check_eq("lat3_rsp_early", t3_rv0, 0);
    end
    @(negedge clk);
    check_eq("lat3_busy_done", t3_busy, 0);
    check_eq("lat3_rsp_valid", t3_rv0, 1);
    check_eq("lat3_result", t3_res0, 16'hFFFB);
    check_eq("lat3_rsp1_quiet", t3_rv1, 0);
    @(negedge clk);
    check_eq("lat3_rsp_pulse", t3_rv0, 0);
    check_eq("lat3_result_hold", t3_res0, 16'hFFFB);
    step(1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      set0($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      set1($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      step(1);
    end
    reset = 1'b0;
    set0(1'b0, 3'd0, 16'd0, 16'd0);
    set1(1'b0, 3'd0, 16'd0, 16'd0);
    step(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single registered ALU (opcode/a/b in, result out, one-clock latency) between two requesters, e.g. the CPU core and a debug/monitor unit.
- Accepts one operation at a time via valid/ready, drives the ALU inputs, waits out the ALU latency, and returns the result to the issuing requester only.
- Sits between the requesters and the ALU instance at the top level.
- Arbitration is round-robin.

Parameters:
- W, 16: operand/result width (signed).
- OPW, 3: ALU opcode width.
- ALU_LAT, 1: ALU clock latency, from inputs stable to result registered. Range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  arbiter accepts req0 this cycle.
- req0_op  in  OPW  requester 0 opcode.
- req0_a  in  W  requester 0 operand a.
- req0_b  in  W  requester 0 operand b.
- rsp0_valid  out  1  one-cycle pulse: rsp0_result is valid.
- rsp0_result  out  W  result for requester 0.
- req1_valid / req1_ready / req1_op / req1_a / req1_b  same as requester 0, for requester 1.
- rsp1_valid / rsp1_result  same as requester 0, for requester 1.
- alu_op  out  OPW  to ALU opcode.
- alu_a  out  W  to ALU a.
- alu_b  out  W  to ALU b.
- alu_result  in  W  from ALU result.
- busy  out  1  high while an op is in flight (state != IDLE).
- grant_id  out  1  requester owning the in-flight op.

Behaviour:
- Reset values (async, immediate):
  - state=IDLE; alu_op/alu_a/alu_b=0; rspN_valid=0; rspN_result=0; busy=0; grant_id=0.
  - last_grant=1, so req0 wins the first tie.
  - reqN_ready forced 0 while reset is high.
- FSM states: IDLE, WAIT, CAPTURE.
- IDLE:
  - Combinational grant: only one valid → that requester; both valid → requester != last_grant.
  - With ALTERNATIVE FIXED PRIORITY (see Optional Feature): req0 always wins.
  - reqN_ready = (state==IDLE) & grantN. Requesters must not make valid depend on ready.
  - On the accept edge T (valid&ready): latch op/a/b into alu_op/alu_a/alu_b; grant_id=N; last_grant=N; load cnt=ALU_LAT; go to WAIT.
  - No valid → stay in IDLE; ALU outputs hold their last values.
- WAIT:
  - ALU inputs held stable.
  - cnt decrements each edge; on the edge where cnt==1, go to CAPTURE.
  - This gives ALU_LAT cycles in WAIT; ready=0 for both requesters.
- CAPTURE:
  - At the next edge, sample alu_result into rsp{grant_id}_result.
  - Pulse rsp{grant_id}_valid for exactly one cycle after that edge.
  - Return to IDLE at the same edge.
  - The other requester's rsp_result and rsp_valid are unchanged (valid=0).
- Timing: accept at edge T → result sampled at edge T+ALU_LAT+1. rsp_valid is high during cycle T+ALU_LAT+1..T+ALU_LAT+2. Next accept is possible at edge T+ALU_LAT+2.
- Throughput: one op per ALU_LAT+2 cycles.
- rspN_result holds its value until that requester's next response.
- No backpressure on responses: requesters must sink rsp_valid when it pulses.
- A requester whose valid drops before being granted loses its turn; no state is kept for it.
- Reset mid-operation: the in-flight op is discarded, no rsp pulse is issued, and the FSM returns to IDLE.
- busy = (state != IDLE).
- Width: operands and result pass through unmodified; no sign handling in the arbiter.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRI_EN.
- Defined:
  - Fixed priority, req0 > req1.
  - last_grant is not used, and its register is removed.
- Undefined (default):
  - Round-robin as specified under Behaviour.

Test Plan:
- Bench ALU model for all cases: registered, 1 cycle, op 3'b000 → a+b.
- Case 1, single requester: reset, then req0 op=0 a=5 b=7 → req0_ready high 1 cycle, alu_a=5/alu_b=7 held 1 cycle, rsp0_valid pulses 1 cycle with rsp0_result=12 at accept+2 edges; rsp1_valid stays 0.
- Case 2, simultaneous requests: req0 and req1 valid continuously from reset release, each op 0 with a=1,b=1 → grant order 0,1,0,1; accepts spaced 3 cycles; each rsp pulse goes only to its owner.
- Case 3, req1 alone then both: req1 only (a=100,b=-1) → rsp1_result=99; then both assert → req0 granted next (last_grant=1).
- Case 4, reset mid-operation: assert reset during WAIT → no rsp pulse, all outputs 0 immediately, busy=0; first op after release completes normally.
- Case 5, ALU_LAT=3 build: req0 a=-8 b=3 → rsp0_result=-5 at accept+4 edges; busy high 4 cycles.
- Case 6, ALU_ARB_FIXED_PRI_EN defined: both valid continuously → req0 granted every time; req1 never granted until req0_valid drops.
